// File: rtl/bmp280_seq.sv
// bmp280_seq: boot and periodic-read sequencer for a BMP280 behind a byte-level SPI engine.
// Boot: wait, read chip ID (with retries), write config then ctrl_meas.
// Run: every PERIOD_CYCLES burst-read 0xF7..0xFC and publish 20-bit raw pressure/temperature.
// Ports:
//   clk12MHz, rst_n            clock, async active-low reset
//   enable                     permits launching burst-read frames
//   spi_start/spi_tx/spi_last  one-cycle byte request to the SPI engine
//   spi_done/spi_rx            byte-complete pulse and received byte
//   press_raw/temp_raw         latest raw words, updated with sample_valid
//   chip_ok/error              ID matched / ID never matched (sticky)
module bmp280_seq #(
    parameter int unsigned STARTUP_CYCLES = 24000,
    parameter int unsigned PERIOD_CYCLES  = 1200000,
    parameter int unsigned GAP_CYCLES     = 4,
    parameter logic [7:0]  CONFIG_VAL     = 8'h00,
    parameter logic [7:0]  CTRL_MEAS_VAL  = 8'h27,
    parameter int unsigned ID_RETRIES     = 3
) (
    input  logic        clk12MHz,
    input  logic        rst_n,
    input  logic        enable,
    output logic        spi_start,
    output logic [7:0]  spi_tx,
    output logic        spi_last,
    input  logic        spi_done,
    input  logic [7:0]  spi_rx,
    output logic [19:0] press_raw,
    output logic [19:0] temp_raw,
    output logic        sample_valid,
    output logic        chip_ok,
    output logic        error
);

    localparam int unsigned ST_W  = $clog2(STARTUP_CYCLES + 1);
    localparam int unsigned PER_W = $clog2(PERIOD_CYCLES + 1);
    localparam int unsigned GAP_W = $clog2(GAP_CYCLES + 2);
    localparam int unsigned AT_W  = $clog2(ID_RETRIES + 1);

    localparam logic [7:0] CHIP_ID = 8'h58;
    localparam logic [7:0] RD_ID   = 8'hD0;  // 0xD0 | 0x80
    localparam logic [7:0] WR_CFG  = 8'h75;  // 0xF5 & 0x7F
    localparam logic [7:0] WR_MEAS = 8'h74;  // 0xF4 & 0x7F
    localparam logic [7:0] RD_DATA = 8'hF7;  // 0xF7 | 0x80

    typedef enum logic [3:0] {
        S_WAIT_PWR, S_ID, S_ID_CHECK, S_CFG, S_MEAS,
        S_IDLE, S_RD, S_PUBLISH, S_ERROR
    } state_e;

    state_e             state_q, state_d;
    logic [ST_W-1:0]    cnt_q, cnt_d;
    logic [PER_W-1:0]   per_q, per_d;
    logic [GAP_W-1:0]   gap_q, gap_d;
    logic [AT_W-1:0]    att_q, att_d;
    logic [2:0]         idx_q, idx_d;     // index of the byte in flight within the frame
    logic               out_q, out_d;     // a byte is outstanding at the engine
    logic [35:0]        sh_q, sh_d;       // {b0, b1, b2[7:4], b3, b4}
    logic               start_q, start_d;
    logic [7:0]         tx_q, tx_d;
    logic               last_q, last_d;
    logic [19:0]        press_q, press_d;
    logic [19:0]        temp_q, temp_d;
    logic               valid_q, valid_d;
    logic               chip_ok_q, chip_ok_d;
    logic               error_q, error_d;

    logic               done_c;
    logic               gap_ok_c;
    logic               iss_c;
    logic [7:0]         iss_tx_c;
    logic               iss_last_c;

    assign done_c   = spi_done && out_q;
    assign gap_ok_c = (gap_q == GAP_W'(GAP_CYCLES));

    // State and output registers
    always_ff @(posedge clk12MHz or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_WAIT_PWR;
            cnt_q     <= '0;
            per_q     <= '0;
            gap_q     <= '0;
            att_q     <= '0;
            idx_q     <= '0;
            out_q     <= 1'b0;
            sh_q      <= '0;
            start_q   <= 1'b0;
            tx_q      <= '0;
            last_q    <= 1'b0;
            press_q   <= '0;
            temp_q    <= '0;
            valid_q   <= 1'b0;
            chip_ok_q <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            per_q     <= per_d;
            gap_q     <= gap_d;
            att_q     <= att_d;
            idx_q     <= idx_d;
            out_q     <= out_d;
            sh_q      <= sh_d;
            start_q   <= start_d;
            tx_q      <= tx_d;
            last_q    <= last_d;
            press_q   <= press_d;
            temp_q    <= temp_d;
            valid_q   <= valid_d;
            chip_ok_q <= chip_ok_d;
            error_q   <= error_d;
        end
    end

    // Next-state and byte-issue logic
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        per_d      = per_q;
        gap_d      = gap_q;
        att_d      = att_q;
        idx_d      = idx_q;
        out_d      = out_q;
        sh_d       = sh_q;
        start_d    = 1'b0;
        tx_d       = tx_q;
        last_d     = 1'b0;
        press_d    = press_q;
        temp_d     = temp_q;
        valid_d    = 1'b0;
        chip_ok_d  = chip_ok_q;
        error_d    = error_q;
        iss_c      = 1'b0;
        iss_tx_c   = 8'h00;
        iss_last_c = 1'b0;

        // Free-running period and inter-frame gap counters, both saturating
        if (per_q != '0) per_d = per_q - PER_W'(1);
        if (!gap_ok_c)   gap_d = gap_q + GAP_W'(1);
        if (done_c)      out_d = 1'b0;

        case (state_q)
            S_WAIT_PWR: begin
                if (cnt_q == ST_W'(STARTUP_CYCLES - 1)) begin
                    cnt_d    = '0;
                    att_d    = att_q + AT_W'(1);
                    idx_d    = '0;
                    iss_c    = 1'b1;
                    iss_tx_c = RD_ID;
                    state_d  = S_ID;
                end else begin
                    cnt_d = cnt_q + ST_W'(1);
                end
            end
            S_ID: begin
                if (done_c) begin
                    if (idx_q == 3'd0) begin
                        idx_d      = 3'd1;
                        iss_c      = 1'b1;
                        iss_last_c = 1'b1;
                    end else begin
                        chip_ok_d = (spi_rx == CHIP_ID);
                        gap_d     = '0;
                        state_d   = S_ID_CHECK;
                    end
                end
            end
            S_ID_CHECK: begin
                idx_d = '0;
                if (chip_ok_q) begin
                    state_d = S_CFG;
                end else if (att_q < AT_W'(ID_RETRIES)) begin
                    state_d = S_WAIT_PWR;
                end else begin
                    error_d = 1'b1;
                    state_d = S_ERROR;
                end
            end
            S_CFG, S_MEAS: begin
                // Two-byte register write; config must precede ctrl_meas while still asleep
                if (!out_q && idx_q == 3'd0 && gap_ok_c) begin
                    iss_c    = 1'b1;
                    iss_tx_c = (state_q == S_CFG) ? WR_CFG : WR_MEAS;
                end else if (done_c) begin
                    if (idx_q == 3'd0) begin
                        idx_d      = 3'd1;
                        iss_c      = 1'b1;
                        iss_tx_c   = (state_q == S_CFG) ? CONFIG_VAL : CTRL_MEAS_VAL;
                        iss_last_c = 1'b1;
                    end else begin
                        idx_d = '0;
                        gap_d = '0;
                        if (state_q == S_CFG) begin
                            state_d = S_MEAS;
                        end else begin
                            per_d   = PER_W'(PERIOD_CYCLES - 1);
                            state_d = S_IDLE;
                        end
                    end
                end
            end
            S_IDLE: begin
                if (per_q == '0 && enable && gap_ok_c) begin
                    iss_c    = 1'b1;
                    iss_tx_c = RD_DATA;
                    per_d    = PER_W'(PERIOD_CYCLES - 1);
                    idx_d    = '0;
                    state_d  = S_RD;
                end
            end
            S_RD: begin
                if (done_c) begin
                    if (idx_q == 3'd6) begin
                        press_d = sh_q[35:16];
                        temp_d  = {sh_q[15:0], spi_rx[7:4]};
                        valid_d = 1'b1;
                        gap_d   = '0;
                        idx_d   = '0;
                        state_d = S_PUBLISH;
                    end else begin
                        // Only the top nibble of b2 is kept (xlsb)
                        if (idx_q == 3'd3)      sh_d = {sh_q[31:0], spi_rx[7:4]};
                        else if (idx_q != 3'd0) sh_d = {sh_q[27:0], spi_rx};
                        idx_d      = idx_q + 3'd1;
                        iss_c      = 1'b1;
                        iss_last_c = (idx_q == 3'd5);
                    end
                end
            end
            S_PUBLISH: state_d = S_IDLE;
            S_ERROR:   state_d = S_ERROR;
            default:   state_d = S_WAIT_PWR;
        endcase

        if (iss_c) begin
            start_d = 1'b1;
            tx_d    = iss_tx_c;
            last_d  = iss_last_c;
            out_d   = 1'b1;
        end
    end

    assign spi_start    = start_q;
    assign spi_tx       = tx_q;
    assign spi_last     = last_q;
    assign press_raw    = press_q;
    assign temp_raw     = temp_q;
    assign sample_valid = valid_q;
    assign chip_ok      = chip_ok_q;
    assign error        = error_q;

endmodule

// File: tb/tb_bmp280_seq.sv
// Scoreboard bench for bmp280_seq with a fixed-latency SPI engine model.
module tb_bmp280_seq;

    localparam int STARTUP = 10;
    localparam int PERIOD  = 200;
    localparam int GAP     = 4;
    localparam int LAT     = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic        spi_start;
    logic [7:0]  spi_tx;
    logic        spi_last;
    logic        spi_done = 1'b0;
    logic [7:0]  spi_rx = 8'h00;
    logic [19:0] press_raw;
    logic [19:0] temp_raw;
    logic        sample_valid;
    logic        chip_ok;
    logic        error;

    bmp280_seq #(
        .STARTUP_CYCLES(STARTUP),
        .PERIOD_CYCLES (PERIOD),
        .GAP_CYCLES    (GAP),
        .CONFIG_VAL    (8'h00),
        .CTRL_MEAS_VAL (8'h27),
        .ID_RETRIES    (3)
    ) dut (
        .clk12MHz    (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .spi_start   (spi_start),
        .spi_tx      (spi_tx),
        .spi_last    (spi_last),
        .spi_done    (spi_done),
        .spi_rx      (spi_rx),
        .press_raw   (press_raw),
        .temp_raw    (temp_raw),
        .sample_valid(sample_valid),
        .chip_ok     (chip_ok),
        .error       (error)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] tx;
        logic       last;
    } txe_t;

    int          n_vec = 0;
    int          n_mis = 0;
    int          cyc = 0;
    txe_t        exp_tx[$];
    logic [39:0] exp_smp[$];
    int          f7_cyc[$];
    int          id_gap[$];
    int          n_starts = 0;
    int          n_smp = 0;
    int          first_start = -1;
    logic        want_first = 1'b0;
    int          last_done_cyc = 0;
    logic        have_done = 1'b0;
    logic        prev_last = 1'b1;
    logic        valid_prev = 1'b0;
    txe_t        mon_e;
    logic [39:0] mon_s;

    // Engine model state
    int          cd = 0;
    logic        cur_last = 1'b0;
    logic [7:0]  frame_first = 8'h00;
    int          bidx = 0;
    int          rd_frames = 0;
    int          cur_pat = 0;
    logic [7:0]  resp = 8'h00;
    logic [7:0]  id_val = 8'h58;
    logic [47:0] pats[3];
    logic [39:0] exp_res[3];
    int          rel_cyc = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input logic [7:0] tx, input logic last);
        txe_t t;
        t.tx   = tx;
        t.last = last;
        exp_tx.push_back(t);
    endtask

    task automatic push_boot();
        push(8'hD0, 1'b0); push(8'h00, 1'b1);
        push(8'h75, 1'b0); push(8'h00, 1'b1);
        push(8'h74, 1'b0); push(8'h27, 1'b1);
    endtask

    task automatic push_rd();
        push(8'hF7, 1'b0);
        for (int i = 0; i < 5; i++) push(8'h00, 1'b0);
        push(8'h00, 1'b1);
    endtask

    task automatic release_rst();
        @(negedge clk); #1;
        rst_n      = 1'b1;
        rel_cyc    = cyc;
        want_first = 1'b1;
    endtask

    task automatic wait_smp(input int n, input int budget, input string name);
        int b = 0;
        while (n_smp < n && b < budget) begin
            @(negedge clk); #1;
            b++;
        end
        chk(name, 64'(n_smp >= n), 1);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // SPI engine model: spi_done LAT cycles after each spi_start
    always @(negedge clk) begin
        if (!rst_n) begin
            spi_done = 1'b0;
            cd       = 0;
            bidx     = 0;
        end else begin
            spi_done = 1'b0;
            if (cd > 0) begin
                cd--;
                if (cd == 0) begin
                    spi_done = 1'b1;
                    spi_rx   = resp;
                    if (cur_last) begin
                        bidx          = 0;
                        last_done_cyc = cyc;
                        have_done     = 1'b1;
                    end else begin
                        bidx++;
                    end
                end
            end
            if (spi_start) begin
                cur_last = spi_last;
                if (bidx == 0) begin
                    frame_first = spi_tx;
                    if (spi_tx == 8'hF7) begin
                        cur_pat = rd_frames % 3;
                        rd_frames++;
                    end
                end
                if (frame_first == 8'hD0 && bidx == 1)
                    resp = id_val;
                else if (frame_first == 8'hF7 && bidx >= 1)
                    resp = pats[cur_pat][47 - 8*(bidx-1) -: 8];
                else
                    resp = 8'hA5;
                cd = LAT;
            end
        end
    end

    // Monitor: pops the scoreboard whenever the DUT presents a byte or a sample
    always @(negedge clk) begin
        if (rst_n) begin
            if (valid_prev) chk("sample_valid_width", 64'(sample_valid), 0);
            valid_prev = sample_valid;
            if (spi_start) begin
                n_starts++;
                if (want_first) begin
                    first_start = cyc;
                    want_first  = 1'b0;
                end
                if (prev_last && have_done) begin
                    chk("frame_gap", 64'((cyc - last_done_cyc) >= GAP), 1);
                    if (spi_tx == 8'hD0) id_gap.push_back(cyc - last_done_cyc);
                end
                if (prev_last && spi_tx == 8'hF7) f7_cyc.push_back(cyc);
                prev_last = spi_last;
                if (exp_tx.size() == 0) begin
                    n_vec++;
                    n_mis++;
                    $display("FAIL unexpected_start: got tx %02h last %0b, none expected (cycle %0d)",
                             spi_tx, spi_last, cyc);
                end else begin
                    mon_e = exp_tx.pop_front();
                    chk("spi_tx_last", 64'({spi_tx, spi_last}), 64'({mon_e.tx, mon_e.last}));
                end
            end
            if (sample_valid) begin
                n_smp++;
                if (exp_smp.size() == 0) begin
                    n_vec++;
                    n_mis++;
                    $display("FAIL unexpected_sample: got %05h/%05h, none expected", press_raw, temp_raw);
                end else begin
                    mon_s = exp_smp.pop_front();
                    chk("press_raw", 64'(press_raw), 64'(mon_s[39:20]));
                    chk("temp_raw",  64'(temp_raw),  64'(mon_s[19:0]));
                end
            end
        end else begin
            valid_prev = 1'b0;
            prev_last  = 1'b1;
        end
    end

    initial begin
        int b;
        int s0;
        int en_c;
        pats[0]    = 48'h655AC07EED00;
        pats[1]    = 48'h12345F89ABCF;
        pats[2]    = 48'hFFFFFF00000F;
        exp_res[0] = 40'h655AC7EED0;
        exp_res[1] = 40'h1234589ABC;
        exp_res[2] = 40'hFFFFF00000;

        // Reset values
        repeat (3) @(negedge clk);
        #1;
        chk("rst_spi_start", 64'(spi_start), 0);
        chk("rst_spi_tx", 64'(spi_tx), 0);
        chk("rst_spi_last", 64'(spi_last), 0);
        chk("rst_press", 64'(press_raw), 0);
        chk("rst_temp", 64'(temp_raw), 0);
        chk("rst_valid", 64'(sample_valid), 0);
        chk("rst_chip_ok", 64'(chip_ok), 0);
        chk("rst_error", 64'(error), 0);

        // Boot, then six read frames with enable held
        push_boot();
        for (int f = 0; f < 6; f++) begin
            push_rd();
            exp_smp.push_back(exp_res[f % 3]);
        end
        enable = 1'b1;
        release_rst();
        wait_smp(5, 3000, "five_samples");
        chk("first_start_delay", 64'(first_start - rel_cyc), STARTUP);
        chk("chip_ok_boot", 64'(chip_ok), 1);
        chk("error_boot", 64'(error), 0);
        chk("f7_count", 64'(f7_cyc.size()), 5);
        for (int i = 1; i < 5 && i < f7_cyc.size(); i++)
            chk("rd_period", 64'(f7_cyc[i] - f7_cyc[i-1]), PERIOD);

        // Drop enable mid-frame: frame completes, no launch until re-enabled
        b = 0;
        while (!(rd_frames == 6 && bidx >= 2) && b < 400) begin
            @(negedge clk); #1;
            b++;
        end
        chk("reach_frame6_byte3", 64'(rd_frames == 6 && bidx >= 2), 1);
        enable = 1'b0;
        wait_smp(6, 200, "frame6_sample");
        chk("samples_consumed", 64'(exp_smp.size()), 0);
        s0 = n_starts;
        b  = 0;
        while (f7_cyc.size() >= 6 && cyc < f7_cyc[5] + 350 && b < 600) begin
            @(negedge clk); #1;
            b++;
        end
        chk("no_start_while_disabled", 64'(n_starts - s0), 0);
        push_rd();
        @(negedge clk); #1;
        enable = 1'b1;
        en_c   = cyc;
        @(negedge clk); #1;
        chk("start_after_enable", 64'(f7_cyc[f7_cyc.size()-1]), 64'(en_c + 1));

        // Reset after the 4th read byte completes
        b = 0;
        while (!(rd_frames == 7 && frame_first == 8'hF7 && bidx == 4) && b < 100) begin
            @(negedge clk); #1;
            b++;
        end
        chk("reach_frame7_done4", 64'(bidx == 4), 1);
        @(posedge clk);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_press", 64'(press_raw), 0);
        chk("midrst_temp", 64'(temp_raw), 0);
        chk("midrst_chip_ok", 64'(chip_ok), 0);
        chk("midrst_spi_start", 64'(spi_start), 0);
        chk("frame7_bytes_left", 64'(exp_tx.size()), 2);
        exp_tx.delete();
        have_done = 1'b0;
        enable    = 1'b0;
        push_boot();
        repeat (2) @(negedge clk);
        release_rst();
        b = 0;
        while (exp_tx.size() != 0 && b < 300) begin
            @(negedge clk); #1;
            b++;
        end
        chk("reboot_done", 64'(exp_tx.size()), 0);
        repeat (20) @(negedge clk);
        #1;
        chk("reboot_start_delay", 64'(first_start - rel_cyc), STARTUP);
        chk("reboot_chip_ok", 64'(chip_ok), 1);

        // ID never matches: three attempts then sticky error
        @(negedge clk); #1;
        rst_n     = 1'b0;
        id_val    = 8'h00;
        have_done = 1'b0;
        id_gap.delete();
        exp_tx.delete();
        for (int i = 0; i < 3; i++) begin
            push(8'hD0, 1'b0);
            push(8'h00, 1'b1);
        end
        repeat (2) @(negedge clk);
        release_rst();
        b = 0;
        while (exp_tx.size() != 0 && b < 500) begin
            @(negedge clk); #1;
            b++;
        end
        chk("id_frames_issued", 64'(exp_tx.size()), 0);
        s0 = n_starts;
        repeat (1000) @(negedge clk);
        #1;
        chk("error_no_start", 64'(n_starts - s0), 0);
        chk("error_flag", 64'(error), 1);
        chk("error_chip_ok", 64'(chip_ok), 0);
        chk("id_retry_count", 64'(id_gap.size()), 2);
        foreach (id_gap[i]) chk("id_retry_wait", 64'(id_gap[i] >= STARTUP), 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

    initial begin
        #500000;
        n_mis++;
        $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/bmp280_seq.md
# bmp280_seq

Sequencer that owns the byte-level SPI engine driving the BMP280 pressure/temperature sensor. After power-up it checks the chip ID, writes `config` and `ctrl_meas`, then periodically burst-reads the six raw measurement registers and publishes 20-bit raw pressure and temperature words. It sits between the SPI byte engine (which drives sck/sdo/csb) and display or consumer logic, and replaces ad-hoc `go` strobing in the top level.

## Interface
- `STARTUP_CYCLES`, 24000: clocks to wait after reset, and between ID retries (2 ms at 12 MHz).
- `PERIOD_CYCLES`, 1200000: clocks between successive burst-read frame starts (100 ms).
- `GAP_CYCLES`, 4: minimum idle clocks after a frame's last byte done before the next frame's first `spi_start`.
- `CONFIG_VAL`, 8'h00: data written to register 0xF5.
- `CTRL_MEAS_VAL`, 8'h27: data written to register 0xF4 (osrs_t=1, osrs_p=1, normal mode).
- `ID_RETRIES`, 3: total ID-read attempts before error.

Ports:
- `clk12MHz` in 1: the single clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `enable` in 1: permits launching burst-read frames.
- `spi_start` out 1: one-cycle request to shift one byte.
- `spi_tx` out 8: byte to send; valid when `spi_start`=1.
- `spi_last` out 1: engine deasserts csb after this byte; valid when `spi_start`=1.
- `spi_done` in 1: one-cycle pulse, byte complete.
- `spi_rx` in 8: received byte; valid when `spi_done`=1.
- `press_raw` out 20: latest raw pressure.
- `temp_raw` out 20: latest raw temperature.
- `sample_valid` out 1: one-cycle pulse when both raw words update.
- `chip_ok` out 1: ID matched 0x58.
- `error` out 1: ID never matched; sticky until reset.

## Operation
- States: WAIT_PWR → ID (2 bytes) → ID_CHECK → CFG (2 bytes) → MEAS (2 bytes) → IDLE ↔ RD (7 bytes) → PUBLISH → IDLE; ERROR is terminal.
- Read address byte = reg | 0x80; write address byte = reg & 0x7F. Dummy tx for reads = 0x00.
- ID frame: tx 0xD0, then 0x00 with `spi_last`. `spi_rx` of the 2nd byte is compared with 0x58.
- ID mismatch: if attempts < `ID_RETRIES`, wait `STARTUP_CYCLES` and retry. Otherwise enter ERROR: `error`=1 and no further `spi_start`.
- CFG frame: 0x75, then `CONFIG_VAL` (last). MEAS frame: 0x74, then `CTRL_MEAS_VAL` (last). Config is written before `ctrl_meas` because the sensor must still be in sleep mode. Both frames run regardless of `enable`.
- RD frame: 0xF7, then six 0x00 bytes. Only the 7th byte carries `spi_last`. Rx bytes 2..7 are b0..b5.
- Assembly: `press_raw` = {b0,b1,b2[7:4]}; `temp_raw` = {b3,b4,b5[7:4]}. Both registers update in the same cycle and `sample_valid` pulses in that cycle.
- IDLE: the period counter runs continuously. An RD frame launches when the counter has expired AND `enable`=1 AND the gap is satisfied. If the counter expires while `enable`=0, the frame launches on the first cycle `enable`=1.
- `enable` dropping mid-frame never aborts the frame. The frame completes and publishes.
- `spi_done` arriving while no byte is outstanding is ignored.

## Timing
- Reset values: `spi_start`=0, `spi_tx`=0, `spi_last`=0, `press_raw`=0, `temp_raw`=0, `sample_valid`=0, `chip_ok`=0, `error`=0. State is WAIT_PWR and all counters are 0.
- WAIT_PWR lasts exactly `STARTUP_CYCLES` clocks after `rst_n` rises. The first `spi_start` is in the next cycle.
- Within a frame, the next `spi_start` is issued the cycle after `spi_done`, so at most one byte is ever outstanding.
- Between frames, the first `spi_start` of the next frame occurs ≥ `GAP_CYCLES` cycles after the last `spi_done` of the previous frame.
- `chip_ok` rises the cycle after the matching ID `spi_done`.
- The period counter reloads on the cycle an RD frame's first `spi_start` is issued, so RD starts are exactly `PERIOD_CYCLES` apart when `enable`=1 and the engine is fast. The counter first loads at the end of the MEAS frame.
- `sample_valid` occurs the cycle after the 7th RD `spi_done` and is one cycle wide.
- Reset mid-frame: outputs return to reset values immediately, and the sequence restarts from WAIT_PWR. The engine's own reset releases csb.

## Test plan
Bench uses `STARTUP_CYCLES`=10, `PERIOD_CYCLES`=200, `GAP_CYCLES`=4, and an engine model with `spi_done` 8 cycles after `spi_start`.

1. Boot with the model returning 0x58 for ID → tx bytes D0,00(last), 75,00(last), 74,27(last). `chip_ok`=1. First `spi_start` is 10 cycles after reset release. Inter-frame gaps are ≥4.
2. Model ID always 0x00 → exactly 3 ID frames, each separated by a ≥10-cycle wait. Then `error`=1 and `spi_start` stays 0 for 1000 cycles.
3. RD rx bytes 65,5A,C0,7E,ED,00 → `press_raw`=0x655AC, `temp_raw`=0x7EED0. `sample_valid` is a single cycle. tx is F7 then six 00, with `spi_last` only on the 7th byte.
4. `enable`=1 held → consecutive F7 `spi_start` pulses are exactly 200 cycles apart over 5 samples.
5. `enable`=0 after the 3rd RD byte → the frame completes and `sample_valid` fires. There is no further `spi_start` past 200 cycles. After `enable`=1, an F7 start occurs the next cycle.
6. `rst_n` low after the 4th RD `spi_done` → `press_raw`/`temp_raw`/`chip_ok` read 0 the same cycle. After release, the ID frame D0 starts 10 cycles later.
